piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter; upstream stage feeding the 4-bit SIPO shift register's serial D input.

---
 rtl/piso_serializer.sv | 90 +++++++++
 tb/tb_piso_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready input handshake.
// Words stream back-to-back with no idle gap; every output except din_ready is registered.
module piso_serializer #(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [WIDTH-1:0]   sreg;
    logic               take;

    assign din_ready = !reset && ((state == IDLE) || ((state == SHIFT) && (cnt == LAST)));
    assign take      = din_valid && din_ready;
    assign cnt_next  = cnt + 1'b1;

    // sreg rotates so the bit currently on sout always sits at the send end;
    // sout is preloaded from the neighbouring position to stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sreg        <= '0;
            sout        <= IDLE_LEVEL;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else if (take) begin
            state       <= SHIFT;
            cnt         <= '0;
            sreg        <= din;
            sout        <= MSB_FIRST ? din[WIDTH-1] : din[0];
            sout_valid  <= 1'b1;
            frame_start <= 1'b1;
            done        <= 1'b0;
            busy        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    sout        <= IDLE_LEVEL;
                    sout_valid  <= 1'b0;
                    frame_start <= 1'b0;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        state       <= IDLE;
                        sout        <= IDLE_LEVEL;
                        sout_valid  <= 1'b0;
                        frame_start <= 1'b0;
                        done        <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        cnt         <= cnt_next;
                        sreg        <= MSB_FIRST ? {sreg[WIDTH-2:0], sreg[WIDTH-1]}
                                                 : {sreg[0], sreg[WIDTH-1:1]};
                        sout        <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
                        frame_start <= 1'b0;
                        done        <= (cnt_next == LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: 4-bit MSB-first, 4-bit LSB-first and 8-bit instances,
// with a behavioural 4-bit SIPO attached to the main instance.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] a_din = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_sout, a_sv, a_fs, a_done, a_busy;

    logic [3:0] b_din = '0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_sout, b_sv, b_fs, b_done, b_busy;

    logic [7:0] c_din = '0;
    logic       c_valid = 1'b0;
    logic       c_ready, c_sout, c_sv, c_fs, c_done, c_busy;

    logic [3:0] sipo_q;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .reset(reset), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
        .sout(a_sout), .sout_valid(a_sv), .frame_start(a_fs), .done(a_done), .busy(a_busy));

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .reset(reset), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
        .sout(b_sout), .sout_valid(b_sv), .frame_start(b_fs), .done(b_done), .busy(b_busy));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
        .clk(clk), .reset(reset), .din(c_din), .din_valid(c_valid), .din_ready(c_ready),
        .sout(c_sout), .sout_valid(c_sv), .frame_start(c_fs), .done(c_done), .busy(c_busy));

    always_ff @(posedge clk) begin
        if (reset) sipo_q <= '0;
        else if (a_sv) sipo_q <= {sipo_q[2:0], a_sout};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_valid = 1'b1;
        a_din = 4'b1111;
        tick();
        tick();
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", a_ready); end
        total++; if ({a_sout, a_sv, a_fs, a_done, a_busy} !== 5'b00000) begin
            bad++; $display("FAIL reset_outputs got=%b want=00000", {a_sout, a_sv, a_fs, a_done, a_busy}); end
        a_valid = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", a_ready); end
        tick();
    endtask

    task automatic test_single;
        logic [3:0] exp;
        exp = 4'b1011;
        a_din = exp;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_din = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            total++; if (a_sout !== exp[3-i] || a_sv !== 1'b1 || a_busy !== 1'b1) begin
                bad++; $display("FAIL single_bit%0d got sout=%b sv=%b busy=%b want sout=%b sv=1 busy=1",
                                i, a_sout, a_sv, a_busy, exp[3-i]); end
            total++; if (a_fs !== (i == 0) || a_done !== (i == 3)) begin
                bad++; $display("FAIL single_flags%0d got fs=%b done=%b want fs=%b done=%b",
                                i, a_fs, a_done, (i == 0), (i == 3)); end
            tick();
        end
        total++; if (a_sv !== 1'b0 || a_sout !== 1'b0 || a_busy !== 1'b0) begin
            bad++; $display("FAIL single_idle got sv=%b sout=%b busy=%b want 0 0 0", a_sv, a_sout, a_busy); end
        total++; if (sipo_q !== 4'b1011) begin bad++; $display("FAIL sipo_q got=%b want=1011", sipo_q); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        exp = 8'b1011_0110;
        a_din = 4'b1011;
        a_valid = 1'b1;
        tick();
        a_din = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            total++; if (a_sout !== exp[7-k] || a_sv !== 1'b1) begin
                bad++; $display("FAIL b2b_bit%0d got sout=%b sv=%b want sout=%b sv=1", k, a_sout, a_sv, exp[7-k]); end
            total++; if (a_done !== (k == 3 || k == 7) || a_fs !== (k == 0 || k == 4)) begin
                bad++; $display("FAIL b2b_flags%0d got done=%b fs=%b", k, a_done, a_fs); end
            if (k == 3) begin
                total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", a_ready); end
            end
            if (k == 4) a_valid = 1'b0;
            tick();
        end
        total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL b2b_idle got sv=%b want=0", a_sv); end
        total++; if (sipo_q !== 4'b0110) begin bad++; $display("FAIL b2b_sipo got=%b want=0110", sipo_q); end
        tick();
    endtask

    task automatic test_midframe_hold;
        logic [7:0] exp;
        exp = 8'b1011_1111;
        a_din = 4'b1011;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_din = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin a_din = 4'b1111; a_valid = 1'b1; end
            if (k >= 1 && k <= 3) begin
                total++; if (a_ready !== (k == 3)) begin
                    bad++; $display("FAIL mid_ready_cnt%0d got=%b want=%b", k, a_ready, (k == 3)); end
            end
            if (k == 4) a_valid = 1'b0;
            total++; if (a_sout !== exp[7-k] || a_sv !== 1'b1 || a_fs !== (k == 0 || k == 4)) begin
                bad++; $display("FAIL mid_bit%0d got sout=%b sv=%b fs=%b want sout=%b", k, a_sout, a_sv, a_fs, exp[7-k]); end
            tick();
        end
        total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL mid_idle got sv=%b want=0", a_sv); end
        tick();
    endtask

    task automatic test_reset_abort;
        logic [3:0] exp;
        a_din = 4'b1011;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        total++; if (a_sout !== 1'b1 || a_sv !== 1'b1) begin
            bad++; $display("FAIL abort_bit2 got sout=%b sv=%b want 1 1", a_sout, a_sv); end
        reset = 1'b1;
        tick();
        total++; if ({a_sout, a_sv, a_done, a_busy, a_ready} !== 5'b00000) begin
            bad++; $display("FAIL abort_reset got=%b want=00000", {a_sout, a_sv, a_done, a_busy, a_ready}); end
        reset = 1'b0;
        tick();
        total++; if (a_done !== 1'b0 || a_sv !== 1'b0) begin
            bad++; $display("FAIL abort_after got done=%b sv=%b want 0 0", a_done, a_sv); end
        exp = 4'b0101;
        a_din = exp;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (a_sout !== exp[3-i] || a_sv !== 1'b1 || a_done !== (i == 3)) begin
                bad++; $display("FAIL abort_next%0d got sout=%b sv=%b done=%b want sout=%b", i, a_sout, a_sv, a_done, exp[3-i]); end
            tick();
        end
        total++; if (sipo_q !== 4'b0101) begin bad++; $display("FAIL abort_sipo got=%b want=0101", sipo_q); end
        tick();
    endtask

    task automatic test_params;
        logic [3:0] exp_b;
        logic [7:0] exp_c;
        exp_b = 4'b1101;
        exp_c = 8'b1010_0101;
        b_din = 4'b1011;
        c_din = 8'hA5;
        b_valid = 1'b1;
        c_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        c_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                total++; if (b_sout !== exp_b[3-i] || b_sv !== 1'b1 || b_done !== (i == 3)) begin
                    bad++; $display("FAIL lsb_bit%0d got sout=%b sv=%b done=%b want sout=%b", i, b_sout, b_sv, b_done, exp_b[3-i]); end
            end
            total++; if (c_sout !== exp_c[7-i] || c_sv !== 1'b1 || c_done !== (i == 7) || c_fs !== (i == 0)) begin
                bad++; $display("FAIL w8_bit%0d got sout=%b sv=%b done=%b fs=%b want sout=%b", i, c_sout, c_sv, c_done, c_fs, exp_c[7-i]); end
            tick();
        end
        total++; if (c_sv !== 1'b0 || b_sv !== 1'b0) begin
            bad++; $display("FAIL param_idle got c_sv=%b b_sv=%b want 0 0", c_sv, b_sv); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_midframe_hold();
        test_reset_abort();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
